addr_gen_fp_aioht_wr: RTL

ADDR_GEN_FP_AIOHT_WR -- requirements
Module: addr_gen_fp_aioht_wr

---
 rtl/addr_gen_fp_aioht_wr.sv | 128 ++++++++++++
 1 files changed

// File: rtl/addr_gen_fp_aioht_wr.sv
// Forward-pass aioht write address generator.
// Produces ascending write addresses NUM_CELL*ts + cell, one per valid cell
// result, across TIMESTEP timesteps, then pulses o_done for one cycle.
//
// state | meaning
// IDLE  | waiting for i_start; pointer/ts hold last values
// RUN   | accepting cell results, o_we follows i_valid
// DONE  | sequence complete, o_done high for one cycle
//
// Optional feature macro: ADDR_GEN_FP_DLY_EN
//   defined   -> o_addr_dly is o_addr_wr registered by one cycle
//   undefined -> o_addr_dly is o_addr_wr passed through
module addr_gen_fp_aioht_wr #(
  parameter int ADDR_WIDTH = 12,
  parameter int NUM_CELL   = 8,
  parameter int TIMESTEP   = 7,
  localparam int TS_W      = (TIMESTEP > 1) ? $clog2(TIMESTEP) : 1,
  localparam int CELL_W    = (NUM_CELL > 1) ? $clog2(NUM_CELL) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_valid,
  input  logic                  i_abort,
  output logic [ADDR_WIDTH-1:0] o_addr_wr,
  output logic                  o_we,
  output logic [ADDR_WIDTH-1:0] o_addr_dly,
  output logic [TS_W-1:0]       o_ts,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CELL_W-1:0] CELL_LAST = CELL_W'(NUM_CELL - 1);
  localparam logic [TS_W-1:0]   TS_LAST   = TS_W'(TIMESTEP - 1);

  state_t                  state_q;
  logic [CELL_W-1:0]       cell_q;
  logic [TS_W-1:0]         ts_q;
  logic [ADDR_WIDTH-1:0]   ptr_q;
  logic                    err_q;

  // Sequencer: state, cell/timestep counters, address pointer and sticky error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cell_q  <= '0;
      ts_q    <= '0;
      ptr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      // A result arriving while not collecting is a protocol error; it never clears.
      if (i_valid && (state_q != RUN)) begin
        err_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (!i_abort && i_start) begin
            state_q <= RUN;
            cell_q  <= '0;
            ts_q    <= '0;
            ptr_q   <= '0;
          end
        end
        RUN: begin
          if (i_abort) begin
            state_q <= IDLE;
          end else if (i_valid) begin
            if (cell_q == CELL_LAST) begin
              cell_q <= '0;
              if (ts_q == TS_LAST) begin
                // Last write: pointer and ts stay on the final address.
                state_q <= DONE;
              end else begin
                ts_q  <= ts_q + TS_W'(1);
                ptr_q <= ptr_q + ADDR_WIDTH'(1);
              end
            end else begin
              cell_q <= cell_q + CELL_W'(1);
              ptr_q  <= ptr_q + ADDR_WIDTH'(1);
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Write strobe follows i_valid in RUN; abort suppresses it in the same cycle.
  always_comb begin
    o_we   = (state_q == RUN) && i_valid && !i_abort;
    o_busy = (state_q == RUN);
    o_done = (state_q == DONE) && !i_abort;
  end

  assign o_addr_wr = ptr_q;
  assign o_ts      = ts_q;
  assign o_err     = err_q;

`ifdef ADDR_GEN_FP_DLY_EN
  logic [ADDR_WIDTH-1:0] dly_q;

  // One-cycle delayed copy of the write address for the gate-derivative store.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dly_q <= '0;
    end else begin
      dly_q <= ptr_q;
    end
  end

  assign o_addr_dly = dly_q;
`else
  assign o_addr_dly = ptr_q;
`endif

endmodule
